// File: rtl/ahb_lite_master.sv
// AHB-Lite burst master: turns one local command into a SINGLE or INCR burst on the bus,
// with checking of alignment, size and 1 KB crossing, ERROR handling and done/err reporting.
module ahb_lite_master #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_size,
  input  logic [3:0]    cmd_len,
  input  logic [DW-1:0] wdata_in,
  output logic          wdata_req,
  output logic [DW-1:0] rdata_out,
  output logic          rdata_valid,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [DW-1:0] hwdata,
  input  logic          hready,
  input  logic          hresp,
  input  logic [DW-1:0] hrdata
);

  localparam logic [1:0] HtIdle   = 2'b00;
  localparam logic [1:0] HtNonseq = 2'b10;
  localparam logic [1:0] HtSeq    = 2'b11;
  localparam logic [2:0] MaxSize  = (DW == 64) ? 3'd3 : 3'd2;

  typedef enum logic [1:0] {StIdle, StAddr, StLast, StErr} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [2:0]    r_size;
  logic [2:0]    r_burst;
  logic [3:0]    r_beats_left;  // address phases still to issue after the current one
  logic          r_first;       // current address phase is the first beat (no data phase yet)
  logic [DW-1:0] r_hwdata;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          r_done;
  logic          r_err;

  logic [AW-1:0] w_mask;
  logic [15:0]   w_span;
  logic          w_bad;
  logic          w_accept;
  logic          w_reject;
  logic          w_addr_done;
  logic          w_rd_done;
  logic          w_finish_ok;
  logic          w_finish_err;

  // Command legality: alignment, transfer size against the bus width, 1 KB crossing.
  assign w_mask = (AW'(1) << cmd_size) - AW'(1);
  assign w_span = {6'd0, cmd_addr[9:0]} + ((16'(cmd_len) + 16'd1) << cmd_size);
  assign w_bad  = ((cmd_addr & w_mask) != '0) || (cmd_size > MaxSize) || (w_span > 16'd1024);

  assign haddr       = r_addr;
  assign hwrite      = r_write;
  assign hsize       = r_size;
  assign hburst      = r_burst;
  assign hwdata      = r_hwdata;
  assign rdata_out   = r_rdata;
  assign rdata_valid = r_rvalid;
  assign done        = r_done;
  assign err         = r_err;

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, bus control outputs and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    htrans       = HtIdle;
    wdata_req    = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_addr_done  = 1'b0;
    w_rd_done    = 1'b0;
    w_finish_ok  = 1'b0;
    w_finish_err = 1'b0;
    unique case (r_state)
      StIdle: begin
        // The cycle carrying done never accepts, so back-to-back commands get a gap.
        cmd_ready = ~r_done;
        if (cmd_valid && !r_done) begin
          if (w_bad) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = StAddr;
          end
        end
      end
      StAddr: begin
        htrans = r_first ? HtNonseq : HtSeq;
        if (!r_first && hresp && !hready) begin
          w_state_next = StErr;
        end else if (hready) begin
          w_addr_done = 1'b1;
          wdata_req   = r_write;
          w_rd_done   = !r_first && !r_write;
          if (r_beats_left == 4'd0) begin
            w_state_next = StLast;
          end
        end
      end
      StLast: begin
        if (hresp && !hready) begin
          w_state_next = StErr;
        end else if (hready) begin
          w_rd_done    = !r_write;
          w_finish_ok  = 1'b1;
          w_state_next = StIdle;
        end
      end
      StErr: begin
        if (hready) begin
          w_finish_err = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Command capture, address stepping, write/read data and completion pulses.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_size       <= 3'd0;
      r_burst      <= 3'd0;
      r_beats_left <= 4'd0;
      r_first      <= 1'b0;
      r_hwdata     <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      if (w_accept) begin
        r_addr       <= cmd_addr;
        r_write      <= cmd_write;
        r_size       <= cmd_size;
        r_burst      <= (cmd_len == 4'd0) ? 3'b000 : 3'b001;
        r_beats_left <= cmd_len;
        r_first      <= 1'b1;
      end
      if (w_reject || w_finish_err) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
      end
      if (w_finish_ok) begin
        r_done <= 1'b1;
      end
      if (w_addr_done) begin
        r_addr  <= r_addr + (AW'(1) << r_size);
        r_first <= 1'b0;
        if (r_beats_left != 4'd0) begin
          r_beats_left <= r_beats_left - 4'd1;
        end
        if (r_write) begin
          r_hwdata <= wdata_in;
        end
      end
      if (w_rd_done) begin
        r_rdata  <= hrdata;
        r_rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: an open-loop transaction model plays the slave and predicts
// every bus/local output per cycle; a negedge process compares DUT against the prediction.
module tb_ahb_lite_master;

  logic        hclk;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [3:0]  cmd_len;
  logic [31:0] wdata_in;
  logic        wdata_req;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  ahb_lite_master #(.DW(32), .AW(32)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_len     (cmd_len),
    .wdata_in    (wdata_in),
    .wdata_req   (wdata_req),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .haddr       (haddr),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hburst      (hburst),
    .hwdata      (hwdata),
    .hready      (hready),
    .hresp       (hresp),
    .hrdata      (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_err = 0;
  int cmd_id = 0;

  // Expected outputs for the current cycle, written by the model just after each posedge.
  logic        chk_en = 1'b0;
  logic [1:0]  e_htrans;
  logic [31:0] e_haddr;
  logic        e_hwrite;
  logic [2:0]  e_hsize;
  logic [2:0]  e_hburst;
  logic        e_check_wd;
  logic [31:0] e_hwdata;
  logic        e_wdata_req;
  logic        e_cmd_ready;
  logic        e_done;
  logic        e_err;
  logic        e_rvalid;
  logic [31:0] e_rdata;

  // Monitor record used by the literal checks of directed cases.
  logic [31:0] alog[$];
  logic [1:0]  tlog[$];
  logic [2:0]  blog[$];
  int          n_wreq;
  int          n_rv;
  int          n_done_err;
  logic [31:0] last_rd;

  logic        use_fixed = 1'b0;
  logic [31:0] fixed_rd  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (chk_en) begin
      check("htrans", 64'(htrans), 64'(e_htrans));
      check("cmd_ready", 64'(cmd_ready), 64'(e_cmd_ready));
      check("wdata_req", 64'(wdata_req), 64'(e_wdata_req));
      check("done", 64'(done), 64'(e_done));
      check("err", 64'(err), 64'(e_err));
      check("rdata_valid", 64'(rdata_valid), 64'(e_rvalid));
      if (e_rvalid) check("rdata_out", 64'(rdata_out), 64'(e_rdata));
      if (e_htrans != 2'b00) begin
        check("haddr", 64'(haddr), 64'(e_haddr));
        check("hwrite", 64'(hwrite), 64'(e_hwrite));
        check("hsize", 64'(hsize), 64'(e_hsize));
        check("hburst", 64'(hburst), 64'(e_hburst));
      end
      if (e_check_wd) check("hwdata", 64'(hwdata), 64'(e_hwdata));
    end
    if (htrans != 2'b00 && hready) begin
      alog.push_back(haddr);
      tlog.push_back(htrans);
      blog.push_back(hburst);
    end
    if (wdata_req) n_wreq++;
    if (rdata_valid) begin
      n_rv++;
      last_rd = rdata_out;
    end
    if (done && err) n_done_err++;
  end

  task automatic clear_mon();
    alog.delete();
    tlog.delete();
    blog.delete();
    n_wreq = 0;
    n_rv = 0;
    n_done_err = 0;
  endtask

  function automatic logic [31:0] wbeat(input int id, input int k);
    return (32'(id) << 16) ^ 32'hBEEF_0000 ^ 32'(k * 3 + 1);
  endfunction

  task automatic exp_quiet();
    e_htrans    = 2'b00;
    e_haddr     = 32'h0;
    e_hwrite    = 1'b0;
    e_hsize     = 3'd0;
    e_hburst    = 3'd0;
    e_check_wd  = 1'b0;
    e_hwdata    = 32'h0;
    e_wdata_req = 1'b0;
    e_cmd_ready = 1'b0;
    e_done      = 1'b0;
    e_err       = 1'b0;
    e_rvalid    = 1'b0;
    e_rdata     = 32'h0;
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_haddr"}, 64'(haddr), 64'd0);
    check({tag, "_htrans"}, 64'(htrans), 64'd0);
    check({tag, "_hwrite"}, 64'(hwrite), 64'd0);
    check({tag, "_hsize"}, 64'(hsize), 64'd0);
    check({tag, "_hburst"}, 64'(hburst), 64'd0);
    check({tag, "_hwdata"}, 64'(hwdata), 64'd0);
    check({tag, "_rdata_out"}, 64'(rdata_out), 64'd0);
    check({tag, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_wdata_req"}, 64'(wdata_req), 64'd0);
  endtask

  // One command, entered and left at posedge+1. The model walks beats by index:
  // ai = next beat whose address phase is on the bus, dph = beat in its data phase.
  // wmode: 0 no waits, 1 random waits, 2 two waits on beat 2's data phase.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] len, input int err_beat, input int wmode,
                         input int rst_beat);
    int          nb = int'(len) + 1;
    int          ai = 0;
    int          dph = -1;
    int          waits = 0;
    int          cyc = 0;
    bit          errored = 1'b0;
    bit          rej;
    bit          p_done = 1'b0;
    bit          p_err = 1'b0;
    bit          p_rv = 1'b0;
    logic [31:0] p_rd = 32'h0;
    logic [31:0] step = 32'd1 << size;
    logic [31:0] span;
    cmd_id++;
    span = 32'(addr % 32'd1024) + 32'(nb) * step;
    rej  = ((addr % step) != 32'd0) || (size > 3'd2) || (span > 32'd1024);

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_len   = len;
    hready    = 1'b1;
    hresp     = 1'b0;
    exp_quiet();
    e_cmd_ready = 1'b1;
    chk_en = 1'b1;
    @(posedge hclk); #1;

    if (rej) begin
      p_done = 1'b1;
      p_err  = 1'b1;
    end else begin
      forever begin
        hready = 1'b1;
        hresp  = 1'b0;
        if (dph >= 0) begin
          if (dph == err_beat) begin
            hready = errored;
            hresp  = 1'b1;
          end else if (wmode == 1) begin
            hready = ($urandom_range(0, 3) != 0);
          end else if (wmode == 2 && dph == 1 && waits < 2) begin
            hready = 1'b0;
            waits++;
          end
        end
        hrdata   = use_fixed ? fixed_rd : $urandom;
        wdata_in = (ai < nb) ? wbeat(cmd_id, ai) : $urandom;

        if (rst_beat >= 0 && ai == rst_beat) begin
          chk_en = 1'b0;
          #2 hresetn = 1'b0;
          #1 reset_values("rst_async");
          cmd_valid = 1'b0;
          @(posedge hclk); #1;
          reset_values("rst_held");
          @(negedge hclk);
          hresetn = 1'b1;
          #1 check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
          @(posedge hclk); #1;
          return;
        end

        exp_quiet();
        e_rvalid = p_rv;
        e_rdata  = p_rd;
        p_rv     = 1'b0;
        if (!errored && ai < nb) begin
          e_htrans = (ai == 0) ? 2'b10 : 2'b11;
          e_haddr  = addr + 32'(ai) * step;
          e_hwrite = wr;
          e_hsize  = size;
          e_hburst = (len == 4'd0) ? 3'b000 : 3'b001;
        end
        e_wdata_req = wr && (e_htrans != 2'b00) && hready;
        if (wr && dph >= 0) begin
          e_check_wd = 1'b1;
          e_hwdata   = wbeat(cmd_id, dph);
        end
        @(posedge hclk); #1;

        cyc++;
        if (cyc > 400) begin
          check("cycle_budget", 64'd1, 64'd0);
          break;
        end
        if (errored) begin
          if (hready) begin
            p_done = 1'b1;
            p_err  = 1'b1;
            break;
          end
        end else if (dph >= 0 && hresp && !hready) begin
          errored = 1'b1;
        end else if (hready) begin
          if (dph >= 0 && !wr) begin
            p_rv = 1'b1;
            p_rd = hrdata;
          end
          if (ai < nb) begin
            dph = ai;
            ai++;
          end else begin
            p_done = 1'b1;
            break;
          end
        end
      end
    end

    // Completion cycle: cmd_valid stays high and must not be accepted here.
    hready = 1'b1;
    hresp  = 1'b0;
    exp_quiet();
    e_done   = p_done;
    e_err    = p_err;
    e_rvalid = p_rv;
    e_rdata  = p_rd;
    @(posedge hclk); #1;
  endtask

  bit          r_wr;
  logic [2:0]  r_sz;
  logic [3:0]  r_ln;
  logic [31:0] r_ad;
  int          r_eb;

  initial begin
    hresetn   = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 3'd0;
    cmd_len   = 4'd0;
    wdata_in  = 32'h0;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    exp_quiet();
    #2 hresetn = 1'b0;
    #1 reset_values("por");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    #1 check("por_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge hclk); #1;

    // Single zero-wait read with a fixed return word.
    clear_mon();
    use_fixed = 1'b1;
    fixed_rd  = 32'hA5A5_0001;
    run_cmd(1'b0, 32'h100, 3'd2, 4'd0, -1, 0, -1);
    use_fixed = 1'b0;
    check("single_nphases", 64'(alog.size()), 64'd1);
    if (alog.size() == 1) begin
      check("single_addr", 64'(alog[0]), 64'h100);
      check("single_trans", 64'(tlog[0]), 64'd2);
      check("single_burst", 64'(blog[0]), 64'd0);
    end
    check("single_nrv", 64'(n_rv), 64'd1);
    check("single_rdata", 64'(last_rd), 64'hA5A5_0001);

    // Four-beat word write with two waits on the second beat's data phase.
    clear_mon();
    run_cmd(1'b1, 32'h200, 3'd2, 4'd3, -1, 2, -1);
    check("wr4_nphases", 64'(alog.size()), 64'd4);
    if (alog.size() == 4) begin
      check("wr4_addr0", 64'(alog[0]), 64'h200);
      check("wr4_addr1", 64'(alog[1]), 64'h204);
      check("wr4_addr2", 64'(alog[2]), 64'h208);
      check("wr4_addr3", 64'(alog[3]), 64'h20C);
      check("wr4_trans0", 64'(tlog[0]), 64'd2);
      check("wr4_trans3", 64'(tlog[3]), 64'd3);
      check("wr4_burst", 64'(blog[0]), 64'd1);
    end
    check("wr4_nwreq", 64'(n_wreq), 64'd4);

    // ERROR on beat 2 of an eight-beat read.
    clear_mon();
    run_cmd(1'b0, 32'h400, 3'd2, 4'd7, 1, 0, -1);
    check("rderr_nphases", 64'(alog.size()), 64'd2);
    check("rderr_nrv", 64'(n_rv), 64'd1);
    check("rderr_doneerr", 64'(n_done_err), 64'd1);

    // Rejected commands: misaligned, 1 KB crossing, oversize.
    clear_mon();
    run_cmd(1'b1, 32'h102, 3'd2, 4'd0, -1, 0, -1);
    run_cmd(1'b0, 32'h3F8, 3'd2, 4'd3, -1, 0, -1);
    run_cmd(1'b0, 32'h000, 3'd3, 4'd0, -1, 0, -1);
    check("rej_nphases", 64'(alog.size()), 64'd0);
    check("rej_doneerr", 64'(n_done_err), 64'd3);

    // Reset in the third beat of a 16-beat write, then a normal read.
    run_cmd(1'b1, 32'h1000, 3'd2, 4'd15, -1, 1, 2);
    clear_mon();
    run_cmd(1'b0, 32'h1040, 3'd2, 4'd3, -1, 1, -1);
    check("post_rst_nrv", 64'(n_rv), 64'd4);

    // Randomized back-to-back commands.
    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      r_ln = 4'($urandom_range(0, 15));
      r_ad = $urandom;
      if ($urandom_range(0, 4) != 0) r_ad = r_ad & ~((32'd1 << r_sz) - 32'd1);
      r_eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(r_ln))) : -1;
      run_cmd(r_wr, r_ad, r_sz, r_ln, r_eb, 1, -1);
    end

    cmd_valid = 1'b0;
    chk_en    = 1'b0;
    repeat (2) @(posedge hclk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
